// File: rtl/datamem_pkg.sv
// Shared types and pure helpers for the datamem_rv data memory.
// Helpers work at the widest supported bus (8 bytes) and address width (64 bits).
`timescale 1ns/1ps
package datamem_pkg;

  localparam int MAX_DATA_BYTES = 8;
  localparam int MAX_ADDR_W     = 64;

  typedef logic [3:0]                  size_t;
  typedef logic [MAX_ADDR_W-1:0]       addr_t;
  typedef logic [8*MAX_DATA_BYTES-1:0] data_t;

  typedef enum logic {EMPTY, FULL} state_e;

  // End address is formed one bit wider than the address so it can never wrap.
  function automatic logic is_legal(addr_t addr, size_t size,
                                    int unsigned memBytes, int unsigned dataBytes);
    logic [MAX_ADDR_W:0] endAddr;
    logic                sizeOk;
    logic                alignOk;
    endAddr = {1'b0, addr} + (MAX_ADDR_W+1)'(size);
    sizeOk  = (size != '0) && ((size & (size - 4'd1)) == '0) && (32'(size) <= dataBytes);
    alignOk = (addr & (addr_t'(size) - addr_t'(1))) == '0;
    return sizeOk && alignOk && (endAddr <= (MAX_ADDR_W+1)'(memBytes));
  endfunction

  function automatic data_t extend(data_t data, size_t size, logic sgn);
    data_t      res;
    logic       fill;
    logic [5:0] topBit;
    topBit = 6'({size, 3'b000} - 7'd1);
    fill   = sgn && (size != '0) && data[topBit];
    res    = data;
    for (int i = 0; i < MAX_DATA_BYTES; i++) begin
      if (i >= int'(size)) res[8*i +: 8] = {8{fill}};
    end
    return res;
  endfunction

endpackage

// File: rtl/datamem_array.sv
// Byte-wide storage with per-lane write enables and a combinational read port.
// Lane i addresses byte addr_i+i; the array is never reset.
`timescale 1ns/1ps
module datamem_array #(
  parameter int MEM_BYTES  = 1024,
  parameter int DATA_BYTES = 8,
  parameter int IDXW       = $clog2(MEM_BYTES)
) (
  input  logic                    clk,
  input  logic [DATA_BYTES-1:0]   wr_en_i,
  input  logic [IDXW-1:0]         addr_i,
  input  logic [8*DATA_BYTES-1:0] wdata_i,
  output logic [8*DATA_BYTES-1:0] rdata_o
);

  logic [7:0] mem_q [MEM_BYTES];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (wr_en_i[i]) mem_q[addr_i + IDXW'(i)] <= wdata_i[8*i +: 8];
    end
  end

  // Lanes past the end wrap around; the top level never enables or uses them.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      rdata_o[8*i +: 8] = mem_q[addr_i + IDXW'(i)];
    end
  end

endmodule

// File: rtl/datamem_rv.sv
// Little-endian data memory with valid/ready requests and a registered,
// stallable one-entry response slot; rejected requests bump a saturating counter.
`timescale 1ns/1ps
module datamem_rv
  import datamem_pkg::*;
#(
  parameter int MEM_BYTES  = 1024,
  parameter int DATA_BYTES = 8,
  parameter int ADDR_W     = 64,
  parameter int ERRCNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic                        req_signed,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [$clog2(DATA_BYTES):0] req_size,
  input  logic [8*DATA_BYTES-1:0]     req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [8*DATA_BYTES-1:0]     resp_rdata,
  output logic                        resp_err,
  output logic [ERRCNT_W-1:0]         err_count
);

  localparam int DW   = 8 * DATA_BYTES;
  localparam int IDXW = $clog2(MEM_BYTES);

  if (MEM_BYTES <= DATA_BYTES || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_mem
    $error("datamem_rv: MEM_BYTES must be a power of two larger than DATA_BYTES");
  end
  if (DATA_BYTES < 1 || DATA_BYTES > MAX_DATA_BYTES || (DATA_BYTES & (DATA_BYTES - 1)) != 0) begin : g_bad_data
    $error("datamem_rv: DATA_BYTES must be a power of two from 1 to 8");
  end
  if (ADDR_W > MAX_ADDR_W || ADDR_W < IDXW) begin : g_bad_addr
    $error("datamem_rv: ADDR_W must cover the array and be at most 64");
  end

  state_e                state_q;
  logic [DW-1:0]         respRdata_q, respRdata_d;
  logic                  respErr_q, respErr_d;
  logic [ERRCNT_W-1:0]   errCount_q;
  logic                  accept, legal, reqHasX;
  logic [DATA_BYTES-1:0] wrEn;
  logic [DW-1:0]         arrRdata;
  size_t                 sizeExt;
  addr_t                 addrExt;

  assign sizeExt   = size_t'(req_size);
  assign addrExt   = addr_t'(req_addr);
  assign req_ready = (state_q == EMPTY) || resp_ready;
  assign accept    = req_valid && req_ready;
  assign legal     = !reqHasX && is_legal(addrExt, sizeExt, MEM_BYTES, DATA_BYTES);

`ifdef SYNTHESIS
  assign reqHasX = 1'b0;
`else
  assign reqHasX = $isunknown({req_addr, req_size});

  assert property (@(posedge clk) disable iff (reset) accept |-> !reqHasX)
    else $warning("datamem_rv: X on request address/size, treated as illegal");
`endif

  always_comb begin
    wrEn = '0;
    if (accept && legal && req_write) begin
      for (int i = 0; i < DATA_BYTES; i++) wrEn[i] = (i < int'(sizeExt));
    end
  end

  datamem_array #(
    .MEM_BYTES (MEM_BYTES),
    .DATA_BYTES(DATA_BYTES),
    .IDXW      (IDXW)
  ) u_array (
    .clk    (clk),
    .wr_en_i(wrEn),
    .addr_i (req_addr[IDXW-1:0]),
    .wdata_i(req_wdata),
    .rdata_o(arrRdata)
  );

  // Stores and rejected requests answer with zero data.
  always_comb begin
    respRdata_d = '0;
    respErr_d   = !legal;
    if (legal && !req_write) begin
      respRdata_d = DW'(extend(data_t'(arrRdata), sizeExt, req_signed));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      respRdata_q <= '0;
      respErr_q   <= 1'b0;
      errCount_q  <= '0;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_q <= FULL;
        FULL:    if (!accept && resp_ready) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        respRdata_q <= respRdata_d;
        respErr_q   <= respErr_d;
        if (!legal && errCount_q != '1) errCount_q <= errCount_q + ERRCNT_W'(1);
      end
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;
  assign err_count  = errCount_q;

endmodule
